// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared sizes and state encoding for the CPU memory responder
package cpu_mem_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    // Highest word address; both pointers turn around here
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // 2'd3 is unused and steers back to ST_LOAD
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2
    } cpuMemState_t;

    // Next pointer value with wrap to zero after the last word
    function automatic logic [ADDR_W-1:0] nextPtr(input logic [ADDR_W-1:0] ptr);
        return (ptr == LAST_ADDR) ? '0 : ptr + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/cpu_mem_array.sv
// rtl/cpu_mem_array.sv - DEPTH x DATA_W register file, one write port, two read ports
module cpu_mem_array
    import cpu_mem_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] cpuAddr,
    output logic [DATA_W-1:0] cpuData,
    input  logic [ADDR_W-1:0] dumpAddr,
    output logic [DATA_W-1:0] dumpData
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage: reset wipes every word, otherwise a single write per edge
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Both read ports are purely combinational so the CPU sees zero wait states
    assign cpuData  = mem[cpuAddr];
    assign dumpData = mem[dumpAddr];

endmodule

// File: rtl/cpu_memory_responder.sv
// rtl/cpu_memory_responder.sv - CPU bus memory with host load, run gating and dump streaming
module cpu_memory_responder
    import cpu_mem_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] memoryIn,
    output logic [DATA_W-1:0] memoryOut,
    output logic              cpu_run,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              dump_req,
    output logic              dp_valid,
    output logic [ADDR_W-1:0] dp_addr,
    output logic [DATA_W-1:0] dp_data,
    input  logic              dp_ready,
    output logic              bus_err
);

    cpuMemState_t      state;
    logic [ADDR_W-1:0] ldPtr;
    logic [ADDR_W-1:0] dpPtr;
    logic              busErrQ;

    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData;
    logic [DATA_W-1:0] cpuRdData;
    logic [DATA_W-1:0] dumpRdData;

    logic inLoad;
    logic inRun;
    logic inDump;

    assign inLoad = (state == ST_LOAD);
    assign inRun  = (state == ST_RUN);
    assign inDump = (state == ST_DUMP);

    // Write-port arbitration: host owns the port in LOAD, CPU owns it in RUN
    always_comb begin
        wrEn   = 1'b0;
        wrAddr = '0;
        wrData = '0;
        case (state)
            ST_LOAD: begin
                wrEn   = ld_valid;
                wrAddr = ldPtr;
                wrData = ld_data;
            end
            ST_RUN: begin
                wrEn   = write;
                wrAddr = address;
                wrData = memoryIn;
            end
            default: begin
                wrEn   = 1'b0;
            end
        endcase
    end

    cpu_mem_array uArray (
        .clk      (clk),
        .clr      (clr),
        .wrEn     (wrEn),
        .wrAddr   (wrAddr),
        .wrData   (wrData),
        .cpuAddr  (address),
        .cpuData  (cpuRdData),
        .dumpAddr (dpPtr),
        .dumpData (dumpRdData)
    );

    // Sequencer: LOAD -> RUN -> DUMP -> LOAD, with the load/dump pointers and sticky bus error
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= ST_LOAD;
            ldPtr   <= '0;
            dpPtr   <= '0;
            busErrQ <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (ld_valid) begin
                        if (ld_last || (ldPtr == LAST_ADDR)) begin
                            ldPtr <= '0;
                            state <= ST_RUN;
                        end else begin
                            ldPtr <= nextPtr(ldPtr);
                        end
                    end
                end
                ST_RUN: begin
                    if (read && write) begin
                        busErrQ <= 1'b1;
                    end
                    if (dump_req) begin
                        dpPtr <= '0;
                        state <= ST_DUMP;
                    end
                end
                ST_DUMP: begin
                    if (dp_ready) begin
                        if (dpPtr == LAST_ADDR) begin
                            dpPtr <= '0;
                            state <= ST_LOAD;
                        end else begin
                            dpPtr <= nextPtr(dpPtr);
                        end
                    end
                end
                default: begin
                    ldPtr <= '0;
                    dpPtr <= '0;
                    state <= ST_LOAD;
                end
            endcase
        end
    end

    // A colliding read/write returns zero; the write still goes through
    assign memoryOut = (inRun && read && !write) ? cpuRdData : '0;

    assign cpu_run  = inRun;
    assign ld_ready = inLoad;
    assign bus_err  = busErrQ;

    // Dump outputs are forced quiet outside DUMP so the host sees nothing stale
    assign dp_valid = inDump;
    assign dp_addr  = inDump ? dpPtr : '0;
    assign dp_data  = inDump ? dumpRdData : '0;

endmodule

// File: tb/tb_cpu_memory_responder.sv
// tb/tb_cpu_memory_responder.sv - randomized self-checking bench for cpu_memory_responder
module tb_cpu_memory_responder;

    logic       clk = 1'b0;
    logic       clr;
    logic       read, write;
    logic [3:0] address;
    logic [7:0] memoryIn;
    logic [7:0] memoryOut;
    logic       cpu_run;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic       dump_req;
    logic       dp_valid;
    logic [3:0] dp_addr;
    logic [7:0] dp_data;
    logic       dp_ready;
    logic       bus_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0=load, 1=run, 2=dump
    int       phase;
    bit [7:0] refMem [16];
    int       ldIdx;
    int       dpIdx;
    bit       refErr;

    always #5 clk = ~clk;

    cpu_memory_responder dut (
        .clk       (clk),
        .clr       (clr),
        .read      (read),
        .write     (write),
        .address   (address),
        .memoryIn  (memoryIn),
        .memoryOut (memoryOut),
        .cpu_run   (cpu_run),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .dump_req  (dump_req),
        .dp_valid  (dp_valid),
        .dp_addr   (dp_addr),
        .dp_data   (dp_data),
        .dp_ready  (dp_ready),
        .bus_err   (bus_err)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        phase  = 0;
        ldIdx  = 0;
        dpIdx  = 0;
        refErr = 0;
        for (int i = 0; i < 16; i++) refMem[i] = 8'h00;
    endtask

    task automatic idleInputs();
        read = 0; write = 0; address = 0; memoryIn = 0;
        ld_valid = 0; ld_data = 0; ld_last = 0;
        dump_req = 0; dp_ready = 0;
    endtask

    task automatic checkOutputs();
        bit [7:0] expOut;
        expOut = (phase == 1 && read && !write) ? refMem[address] : 8'h00;
        checkVal("memoryOut", memoryOut, expOut);
        checkVal("cpu_run", cpu_run, phase == 1);
        checkVal("ld_ready", ld_ready, phase == 0);
        checkVal("dp_valid", dp_valid, phase == 2);
        checkVal("dp_addr", dp_addr, phase == 2 ? dpIdx : 0);
        checkVal("dp_data", dp_data, phase == 2 ? refMem[dpIdx] : 8'h00);
        checkVal("bus_err", bus_err, refErr);
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the edge
    task automatic cycle();
        @(negedge clk);
        checkOutputs();
        @(posedge clk);
        #1;
        case (phase)
            0: if (ld_valid) begin
                refMem[ldIdx] = ld_data;
                if (ld_last || ldIdx == 15) begin
                    ldIdx = 0;
                    phase = 1;
                end else begin
                    ldIdx++;
                end
            end
            1: begin
                if (write) refMem[address] = memoryIn;
                if (read && write) refErr = 1;
                if (dump_req) begin
                    phase = 2;
                    dpIdx = 0;
                end
            end
            default: if (dp_ready) begin
                if (dpIdx == 15) begin
                    phase = 0;
                    dpIdx = 0;
                end else begin
                    dpIdx++;
                end
            end
        endcase
    endtask

    // Reset between edges and confirm the outputs drop without any clock edge
    task automatic asyncReset();
        #2;
        clr = 0;
        #1;
        modelReset();
        checkVal("rst_dp_valid", dp_valid, 0);
        checkVal("rst_ld_ready", ld_ready, 1);
        checkVal("rst_cpu_run", cpu_run, 0);
        checkVal("rst_dp_data", dp_data, 0);
        checkVal("rst_bus_err", bus_err, 0);
        idleInputs();
        @(negedge clk);
        clr = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic loadByte(input logic [7:0] d, input logic last);
        idleInputs();
        ld_valid = 1; ld_data = d; ld_last = last;
        cycle();
        idleInputs();
    endtask

    initial begin
        int budget;
        int addrSeen [$];

        idleInputs();
        modelReset();
        clr = 0;
        #3;
        checkOutputs();
        @(negedge clk);
        clr = 1;
        @(posedge clk);
        #1;

        // Short load terminated by ld_last
        loadByte(8'h15, 0);
        loadByte(8'h94, 0);
        loadByte(8'h07, 1);
        checkVal("t1_cpu_run", cpu_run, 1);

        // Zero-wait read, then idle bus
        read = 1; address = 4'd1;
        #1 checkVal("t2_read", memoryOut, 8'h94);
        cycle();
        read = 0;
        #1 checkVal("t2_idle", memoryOut, 8'h00);
        cycle();

        // Write then read back next cycle
        write = 1; address = 4'd9; memoryIn = 8'hA5;
        cycle();
        write = 0; read = 1;
        #1 checkVal("t3_readback", memoryOut, 8'hA5);
        checkVal("t3_bus_err", bus_err, 0);
        cycle();

        // Collision: write wins, read returns zero, error sticks
        read = 1; write = 1; address = 4'd2; memoryIn = 8'h3C;
        #1 checkVal("t4_collide_out", memoryOut, 8'h00);
        cycle();
        write = 0;
        #1 checkVal("t4_mem2", memoryOut, 8'h3C);
        checkVal("t4_bus_err", bus_err, 1);
        cycle();
        read = 0;
        cycle();
        checkVal("t4_bus_err_held", bus_err, 1);

        // Dump what is there, return to LOAD, then full 16-byte load
        dump_req = 1;
        cycle();
        dump_req = 0; dp_ready = 1;
        for (int i = 0; i < 16; i++) cycle();
        dp_ready = 0;
        checkVal("t5_back_to_load", ld_ready, 1);
        for (int i = 0; i < 16; i++) loadByte(8'($urandom), 0);
        checkVal("t5_run_after16", cpu_run, 1);
        dump_req = 1;
        cycle();
        dump_req = 0;
        budget = 0;
        while (phase == 2 && budget < 64) begin
            dp_ready = budget[0];
            if (dp_valid && dp_ready) addrSeen.push_back(int'(dp_addr));
            cycle();
            budget++;
        end
        dp_ready = 0;
        checkVal("t5_dump_count", addrSeen.size(), 16);
        foreach (addrSeen[i]) checkVal("t5_dump_order", addrSeen[i], i);
        checkVal("t5_ld_ready", ld_ready, 1);

        // Reset in the middle of a dump
        for (int i = 0; i < 16; i++) loadByte(8'($urandom_range(1, 255)), 0);
        dump_req = 1;
        cycle();
        dump_req = 0; dp_ready = 1;
        budget = 0;
        while (dpIdx != 5 && budget < 32) begin
            cycle();
            budget++;
        end
        checkVal("t6_reached_ptr5", dp_addr, 5);
        asyncReset();
        loadByte(8'h5A, 1);
        for (int a = 0; a < 16; a++) begin
            read = 1; address = 4'(a);
            #1 checkVal("t6_cleared", memoryOut, (a == 0) ? 8'h5A : 8'h00);
            cycle();
        end
        idleInputs();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            ld_valid = ($urandom_range(0, 2) != 0);
            ld_data  = 8'($urandom);
            ld_last  = ($urandom_range(0, 7) == 0);
            read     = ($urandom_range(0, 1) == 1);
            write    = ($urandom_range(0, 4) == 0);
            address  = 4'($urandom);
            memoryIn = 8'($urandom);
            dump_req = ($urandom_range(0, 15) == 0);
            dp_ready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 499) == 0) asyncReset();
            else cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
